// File: rtl/cic4_decimator.sv
// cic4_decimator: 4th-order CIC decimator (R = 2^R_LOG2, M = 1). It is the
// first stage of the ADC decimation chain and feeds hb1_filter.
//   clk          system clock
//   rst          synchronous active-high reset
//   clk_vld_in   modulator sample strobe
//   dat_in       signed modulator sample (IN_W bits)
//   clk_vld_out  one-clk pulse: dat_out holds a new decimated sample
//   dat_out      signed decimated sample, gain R^N * 2^OUT_SHIFT per LSB
module cic4_decimator #(
    parameter int unsigned IN_W      = 4,
    parameter int unsigned N         = 4,
    parameter int unsigned R_LOG2    = 5,
    parameter int unsigned OUT_SHIFT = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_vld_in,
    input  logic signed [IN_W-1:0] dat_in,
    output logic                   clk_vld_out,
    output logic signed [34:0]     dat_out
);

    localparam int unsigned W     = IN_W + N * R_LOG2;
    localparam int unsigned OUT_W = 35;
    localparam logic [R_LOG2-1:0] CNT_LAST = '1;

    logic [W-1:0]          integ_q  [N];
    logic [W-1:0]          integ_d  [N];
    logic [W-1:0]          comb_z_q [N];
    logic [W-1:0]          comb_z_d [N];
    logic [W-1:0]          comb_in_c [N];
    logic [W-1:0]          comb_acc_c;
    logic [R_LOG2-1:0]     cnt_q, cnt_d;
    logic                  dec_c;
    logic                  vld_out_q, vld_out_d;
    logic signed [OUT_W-1:0] dat_out_q, dat_out_d;
    logic signed [OUT_W-1:0] comb_ext_c;

    // Next-state: integrator cascade, decimation counter, comb chain, output.
    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            integ_d[k]  = integ_q[k];
            comb_z_d[k] = comb_z_q[k];
        end
        cnt_d      = cnt_q;
        vld_out_d  = 1'b0;
        dat_out_d  = dat_out_q;
        dec_c      = 1'b0;

        // Integrators all use pre-edge values, so the cascade is registered.
        if (clk_vld_in) begin
            integ_d[0] = integ_q[0] + W'($signed(dat_in));
            for (int k = 1; k < int'(N); k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            cnt_d = cnt_q + R_LOG2'(1);
            dec_c = (cnt_q == CNT_LAST);
        end

        // Comb chain evaluated combinationally from the pre-edge last integrator.
        comb_acc_c = integ_q[N-1];
        for (int k = 0; k < int'(N); k++) begin
            comb_in_c[k] = comb_acc_c;
            comb_acc_c   = comb_acc_c - comb_z_q[k];
        end
        comb_ext_c = OUT_W'($signed(comb_acc_c));

        if (dec_c) begin
            for (int k = 0; k < int'(N); k++) begin
                comb_z_d[k] = comb_in_c[k];
            end
            dat_out_d = comb_ext_c <<< OUT_SHIFT;
            vld_out_d = 1'b1;
        end
    end

    // State registers; wrap-around in integrators and combs is intentional.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N); k++) begin
                integ_q[k]  <= '0;
                comb_z_q[k] <= '0;
            end
            cnt_q     <= '0;
            vld_out_q <= 1'b0;
            dat_out_q <= '0;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                integ_q[k]  <= integ_d[k];
                comb_z_q[k] <= comb_z_d[k];
            end
            cnt_q     <= cnt_d;
            vld_out_q <= vld_out_d;
            dat_out_q <= dat_out_d;
        end
    end

    assign clk_vld_out = vld_out_q;
    assign dat_out     = dat_out_q;

endmodule

// File: tb/tb_cic4_decimator.sv
// Directed-vector bench for cic4_decimator with hand-computed CIC4 R=32 values.
module tb_cic4_decimator;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_vld_in;
    logic signed [3:0] dat_in;
    logic              clk_vld_out;
    logic signed [34:0] dat_out;

    cic4_decimator dut (
        .clk         (clk),
        .rst         (rst),
        .clk_vld_in  (clk_vld_in),
        .dat_in      (dat_in),
        .clk_vld_out (clk_vld_out),
        .dat_out     (dat_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output capture on the falling edge.
    longint      out_val[$];
    int unsigned out_cyc[$];
    int          wide_cnt = 0;
    logic        prev_vld = 1'b0;
    always @(negedge clk) begin
        if (clk_vld_out) begin
            out_val.push_back(longint'(dat_out));
            out_cyc.push_back(cyc);
            if (prev_vld) wide_cnt++;
        end
        prev_vld = clk_vld_out;
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int          strobe_cnt  = 0;
    int unsigned first32_cyc = 0;

    // Drive n strobes of value v (random if rnd), one strobe every gap clks.
    task automatic drive(input int n, input logic [3:0] v, input int gap, input bit rnd);
        for (int i = 0; i < n; i++) begin
            clk_vld_in = 1'b1;
            dat_in     = rnd ? 4'($urandom) : v;
            @(posedge clk); #1;
            strobe_cnt++;
            if (strobe_cnt == 32) first32_cyc = cyc;
            clk_vld_in = 1'b0;
            for (int g = 1; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            clk_vld_in = 1'b1;
            dat_in     = 4'($urandom);
            @(posedge clk); #1;
        end
        rst        = 1'b0;
        clk_vld_in = 1'b0;
        dat_in     = '0;
        out_val.delete();
        out_cyc.delete();
        strobe_cnt = 0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Step response from reset, continuous strobes, dat_in = +1.
    longint dc_exp [6] = '{64'd32220160, 64'd481080320, 64'd1013427200,
                           64'd1073740800, 64'd1073741824, 64'd1073741824};
    // Impulse response sampled at the decimation phase, scaled by 2^10.
    longint imp_exp [8] = '{64'd4157440, 64'd22097920, 64'd7294976, 64'd4096,
                            64'd0, 64'd0, 64'd0, 64'd0};

    task automatic check_dc(input string tag);
        check({tag, "_count"}, longint'(out_val.size()), 64'd6);
        check({tag, "_first_cyc"}, longint'(out_cyc.size() > 0 ? out_cyc[0] : 0),
              longint'(first32_cyc));
        for (int i = 0; i < 6; i++) begin
            if (i < out_val.size())
                check($sformatf("%s_out%0d", tag, i), out_val[i], dc_exp[i]);
        end
    endtask

    initial begin
        longint sum;
        rst        = 1'b1;
        clk_vld_in = 1'b0;
        dat_in     = '0;

        // Reset with random input and strobes active.
        out_val.delete();
        do_reset(3);
        check("rst_dat_out", longint'(dat_out), 64'd0);
        check("rst_vld_out", longint'(clk_vld_out), 64'd0);
        check("rst_no_pulse", longint'(out_val.size()), 64'd0);

        // DC gain.
        drive(192, 4'd1, 1, 1'b0);
        settle();
        check_dc("dc");

        // Negative full scale.
        do_reset(2);
        drive(192, 4'd8, 1, 1'b0);
        settle();
        check("neg_count", longint'(out_val.size()), 64'd6);
        for (int i = 4; i < 6; i++) begin
            if (i < out_val.size())
                check($sformatf("neg_out%0d", i), out_val[i], -64'sd8589934592);
        end

        // Strobe gaps: one strobe every 3 clk.
        do_reset(2);
        drive(192, 4'd3, 3, 1'b0);
        settle();
        check("gap_count", longint'(out_val.size()), 64'd6);
        if (out_val.size() >= 6) begin
            check("gap_out4", out_val[4], 64'd3221225472);
            check("gap_out5", out_val[5], 64'd3221225472);
            check("gap_spacing", longint'(out_cyc[5] - out_cyc[4]), 64'd96);
        end

        // Impulse.
        do_reset(2);
        drive(1, 4'd1, 1, 1'b0);
        drive(255, 4'd0, 1, 1'b0);
        settle();
        check("imp_count", longint'(out_val.size()), 64'd8);
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < out_val.size()) begin
                check($sformatf("imp_out%0d", i), out_val[i], imp_exp[i]);
                sum += out_val[i];
            end
        end
        check("imp_sum", sum, 64'd33554432);

        // Mid-frame reset after 17 strobes, then the DC sequence again.
        do_reset(2);
        drive(17, 4'd0, 1, 1'b1);
        do_reset(1);
        drive(192, 4'd1, 1, 1'b0);
        settle();
        check_dc("mid");

        check("pulse_width", longint'(wide_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
